// File: rtl/av_codec_i2c_config.sv
// WM8731 power-up configurator: after a start-up delay, writes ten register words over I2C, then idles.
// Optional `ACK_CHECK_EN: a NACK aborts the transaction, issues STOP and GAP, and retries the same entry.
module av_codec_i2c_config #(
  parameter int unsigned CLK_FREQ      = 50_000_000,
  parameter int unsigned I2C_FREQ      = 20_000,
  parameter logic [7:0]  DEV_ADDR      = 8'h34,
  parameter int unsigned STARTUP_DELAY = 65535
) (
  input  logic iCLK,
  input  logic Reset,
  output logic oI2C_SCLK,
  inout  wire  I2C_SDAT,
  output logic oCONFIG_DONE,
  output logic oACK_ERR,
  output logic oBUSY
);
  localparam int unsigned Q  = CLK_FREQ / (4 * I2C_FREQ);
  localparam int unsigned TW = (Q > 1) ? $clog2(Q) : 1;
  localparam int unsigned DW = (STARTUP_DELAY > 1) ? $clog2(STARTUP_DELAY) : 1;

  typedef enum logic [2:0] {
    WAIT_STARTUP, START, SEND_BIT, ACK_BIT, STOP, GAP, DONE
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      phase_q, phase_d;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [DW-1:0]   dly_q, dly_d;
  logic [3:0]      idx_q, idx_d;
  logic [1:0]      byte_q, byte_d;
  logic [2:0]      bit_q, bit_d;
  logic            ack_err_q, ack_err_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic            scl_q, scl_d;
  logic            sda_low_q, sda_low_d;
`ifdef ACK_CHECK_EN
  logic            nack_q, nack_d;
  logic            retry_q, retry_d;
`endif
  logic            tick;
  logic            abort;
  logic            retry;
  logic            sda_in;
  logic [15:0]     cur_word;
  logic [7:0]      cur_byte;

  function automatic logic [15:0] cfg_word(input logic [3:0] idx);
    case (idx)
      4'd0:    return 16'h001A;
      4'd1:    return 16'h021A;
      4'd2:    return 16'h047B;
      4'd3:    return 16'h067B;
      4'd4:    return 16'h08F8;
      4'd5:    return 16'h0A06;
      4'd6:    return 16'h0C00;
      4'd7:    return 16'h0E01;
      4'd8:    return 16'h1002;
      default: return 16'h1201;
    endcase
  endfunction

  assign sda_in   = I2C_SDAT;
  assign I2C_SDAT = sda_low_q ? 1'b0 : 1'bz;

  assign oI2C_SCLK    = scl_q;
  assign oCONFIG_DONE = done_q;
  assign oACK_ERR     = ack_err_q;
  assign oBUSY        = busy_q;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    dly_d      = dly_q;
    idx_d      = idx_q;
    byte_d     = byte_q;
    bit_d      = bit_q;
    ack_err_d  = ack_err_q;
`ifdef ACK_CHECK_EN
    nack_d     = nack_q;
    retry_d    = retry_q;
    abort      = nack_q;
    retry      = retry_q;
`else
    abort      = 1'b0;
    retry      = 1'b0;
`endif
    tick = (tick_cnt_q == TW'(Q - 1));
    if (state_q == WAIT_STARTUP || state_q == DONE || tick) tick_cnt_d = '0;
    else                                                  tick_cnt_d = tick_cnt_q + TW'(1);
    if (state_q != WAIT_STARTUP && state_q != DONE && tick) phase_d = phase_q + 2'd1;

    case (state_q)
      WAIT_STARTUP: begin
        if (dly_q == DW'(STARTUP_DELAY - 1)) begin
          state_d = START;
          phase_d = 2'd0;
          idx_d   = 4'd0;
        end else begin
          dly_d = dly_q + DW'(1);
        end
      end
      START: if (tick && phase_q == 2'd3) begin
        state_d = SEND_BIT;
        byte_d  = 2'd0;
        bit_d   = 3'd7;
      end
      SEND_BIT: if (tick && phase_q == 2'd3) begin
        if (bit_q == 3'd0) state_d = ACK_BIT;
        else               bit_d   = bit_q - 3'd1;
      end
      ACK_BIT: begin
        // A released line that still reads high during SCL-high is a NACK.
        if (tick && phase_q == 2'd2 && sda_in) begin
          ack_err_d = 1'b1;
`ifdef ACK_CHECK_EN
          nack_d = 1'b1;
`endif
        end
        if (tick && phase_q == 2'd3) begin
`ifdef ACK_CHECK_EN
          nack_d = 1'b0;
          if (nack_q) retry_d = 1'b1;
`endif
          if (abort || byte_q == 2'd2) begin
            state_d = STOP;
          end else begin
            state_d = SEND_BIT;
            byte_d  = byte_q + 2'd1;
            bit_d   = 3'd7;
          end
        end
      end
      STOP: if (tick && phase_q == 2'd3) state_d = GAP;
      GAP: if (tick && phase_q == 2'd3) begin
        if (retry) begin
          state_d = START;
`ifdef ACK_CHECK_EN
          retry_d = 1'b0;
`endif
        end else if (idx_q < 4'd9) begin
          state_d = START;
          idx_d   = idx_q + 4'd1;
        end else begin
          state_d = DONE;
        end
      end
      default: ;
    endcase

    // Outputs are decoded from the next state so the pins change in step with the state register.
    cur_word = cfg_word(idx_d);
    case (byte_d)
      2'd0:    cur_byte = DEV_ADDR;
      2'd1:    cur_byte = cur_word[15:8];
      default: cur_byte = cur_word[7:0];
    endcase
    scl_d     = 1'b1;
    sda_low_d = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    case (state_d)
      START: begin
        busy_d    = 1'b1;
        scl_d     = (phase_d != 2'd3);
        sda_low_d = (phase_d != 2'd0);
      end
      SEND_BIT: begin
        busy_d    = 1'b1;
        scl_d     = (phase_d == 2'd1) || (phase_d == 2'd2);
        sda_low_d = ~cur_byte[bit_d];
      end
      ACK_BIT: begin
        busy_d = 1'b1;
        scl_d  = (phase_d == 2'd1) || (phase_d == 2'd2);
      end
      STOP: begin
        busy_d    = 1'b1;
        scl_d     = (phase_d != 2'd0);
        sda_low_d = (phase_d != 2'd3);
      end
      GAP:     busy_d = 1'b1;
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (Reset) begin
      state_q    <= WAIT_STARTUP;
      phase_q    <= 2'd0;
      tick_cnt_q <= '0;
      dly_q      <= '0;
      idx_q      <= 4'd0;
      byte_q     <= 2'd0;
      bit_q      <= 3'd7;
      ack_err_q  <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      scl_q      <= 1'b1;
      sda_low_q  <= 1'b0;
`ifdef ACK_CHECK_EN
      nack_q     <= 1'b0;
      retry_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      tick_cnt_q <= tick_cnt_d;
      dly_q      <= dly_d;
      idx_q      <= idx_d;
      byte_q     <= byte_d;
      bit_q      <= bit_d;
      ack_err_q  <= ack_err_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      scl_q      <= scl_d;
      sda_low_q  <= sda_low_d;
`ifdef ACK_CHECK_EN
      nack_q     <= nack_d;
      retry_q    <= retry_d;
`endif
    end
  end

endmodule

// File: tb/tb_av_codec_i2c_config.sv
// Bench for av_codec_i2c_config: bus-level I2C decoder and ACKing slave, scored against a transaction-level model.
module tb_av_codec_i2c_config;
  localparam int CLK_FREQ = 400;
  localparam int I2C_FREQ = 10;
  localparam int SD       = 20;
  localparam int Q        = CLK_FREQ / (4 * I2C_FREQ);
  localparam logic [7:0] DEV = 8'h34;

  typedef struct {
    int          nbits;
    logic [26:0] bits;
  } tx_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl, done, ack_err, busy;
  logic ack_drive = 1'b0;
  wire  sda_w;

  pullup (sda_w);
  assign sda_w = (ack_drive && !rst) ? 1'b0 : 1'bz;

  av_codec_i2c_config #(
    .CLK_FREQ(CLK_FREQ), .I2C_FREQ(I2C_FREQ), .DEV_ADDR(DEV), .STARTUP_DELAY(SD)
  ) dut (
    .iCLK(clk), .Reset(rst), .oI2C_SCLK(scl), .I2C_SDAT(sda_w),
    .oCONFIG_DONE(done), .oACK_ERR(ack_err), .oBUSY(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] TBL [10] = '{16'h001A, 16'h021A, 16'h047B, 16'h067B, 16'h08F8,
                            16'h0A06, 16'h0C00, 16'h0E01, 16'h1002, 16'h1201};

  int n_cmp = 0;
  int n_err = 0;
  tx_t exp_q[$];

  logic        prev_scl, prev_sda, in_tx, have_rise, rise_bit;
  logic [26:0] shreg;
  int          bit_no, start_cnt, rx_cnt, first_start_cyc;
  int          nack_tx, nack_ack;
  bit          nack_armed;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // I2C bus monitor and slave: bits latched on SCL rise, committed on SCL fall.
  always @(negedge clk) begin : mon
    logic s, d;
    int   k;
    s = scl;
    d = sda_w;
    if (rst) begin
      in_tx = 1'b0; have_rise = 1'b0; ack_drive = 1'b0;
      prev_scl = 1'b1; prev_sda = 1'b1;
    end else begin
      if (prev_scl && s && prev_sda && !d) begin
        if (start_cnt == 0) first_start_cyc = cyc;
        start_cnt++;
        in_tx = 1'b1; bit_no = 0; shreg = '0; have_rise = 1'b0;
        chk("busy_in_tx", busy, 1);
      end else if (prev_scl && s && !prev_sda && d) begin
        if (in_tx) begin
          if (rx_cnt < exp_q.size()) begin
            chk($sformatf("tx%0d_nbits", rx_cnt), bit_no, exp_q[rx_cnt].nbits);
            chk($sformatf("tx%0d_bits", rx_cnt), shreg, exp_q[rx_cnt].bits);
          end else begin
            chk("tx_extra", rx_cnt, exp_q.size());
          end
          rx_cnt++;
        end
        in_tx = 1'b0; have_rise = 1'b0;
      end else if (in_tx && !prev_scl && s) begin
        rise_bit = d; have_rise = 1'b1;
      end else if (in_tx && prev_scl && !s) begin
        if (have_rise) begin
          shreg = {shreg[25:0], rise_bit};
          bit_no++;
          have_rise = 1'b0;
        end
        if (bit_no == 8 || bit_no == 17 || bit_no == 26) begin
          k = (bit_no + 1) / 9;
          if (nack_armed && (start_cnt - 1) == nack_tx && k == nack_ack) begin
            ack_drive = 1'b0; nack_armed = 1'b0;
          end else begin
            ack_drive = 1'b1;
          end
        end else begin
          ack_drive = 1'b0;
        end
      end
      prev_scl = s; prev_sda = d;
    end
  end

  task automatic run_seq(input int ntx_nack, input int nack_k, input bit mid_reset);
    tx_t         r;
    logic [26:0] full, nk;
    int          n, t, rel, total, lim;
    logic        idle_ok;
    exp_q.delete();
    for (int e = 0; e < 10; e++) begin
      full = {DEV, 1'b0, TBL[e][15:8], 1'b0, TBL[e][7:0], 1'b0};
      if (e == ntx_nack) begin
        nk = full | (27'd1 << (27 - 9 * nack_k));
`ifdef ACK_CHECK_EN
        r.nbits = 9 * nack_k; r.bits = nk >> (27 - 9 * nack_k); exp_q.push_back(r);
        r.nbits = 27;         r.bits = full;                    exp_q.push_back(r);
`else
        r.nbits = 27; r.bits = nk; exp_q.push_back(r);
`endif
      end else begin
        r.nbits = 27; r.bits = full; exp_q.push_back(r);
      end
    end
    rx_cnt = 0; start_cnt = 0; first_start_cyc = 0;
    nack_tx = ntx_nack; nack_ack = nack_k; nack_armed = (ntx_nack >= 0);

    @(negedge clk);
    rst = 1'b0;
    rel = cyc;
    n = 0;
    while (start_cnt == 0 && n < SD + Q + 100) begin @(negedge clk); n++; end
    t = first_start_cyc - rel;
    chk($sformatf("start_time_%0d", t), (start_cnt > 0 && t >= SD + Q - 1 && t <= SD + Q + 1), 1);

    if (mid_reset) begin
      n = 0;
      while (start_cnt < 6 && n < 8000) begin @(negedge clk); n++; end
      chk("reach_entry5", start_cnt >= 6, 1);
      repeat ($urandom_range(1, 900)) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_scl", scl, 1);
      chk("mid_rst_sda", sda_w, 1);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_ackerr", ack_err, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_rx", rx_cnt, 5);
      repeat (2) @(negedge clk);
      return;
    end

    total = 0;
    foreach (exp_q[i]) total += 12 + 4 * exp_q[i].nbits;
    lim = SD + Q * total + 200;
    n = 0;
    while (done !== 1'b1 && n < lim) begin @(negedge clk); n++; end
    t = cyc - rel;
    chk($sformatf("done_time_%0d_vs_%0d", t, SD + Q * total),
        (done === 1'b1 && t >= SD + Q * total - 1 && t <= SD + Q * total + 1), 1);
    chk("tx_count", rx_cnt, exp_q.size());
    chk("ack_err", ack_err, (ntx_nack >= 0));
    idle_ok = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (!(scl === 1'b1 && sda_w === 1'b1 && done === 1'b1 && busy === 1'b0)) idle_ok = 1'b0;
    end
    chk("idle_after_done", idle_ok, 1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int e, k;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_scl", scl, 1);
    chk("rst_sda", sda_w, 1);
    chk("rst_done", done, 0);
    chk("rst_ackerr", ack_err, 0);
    chk("rst_busy", busy, 0);

    run_seq(-1, 0, 1'b0);
    run_seq(3, 2, 1'b0);
    run_seq(-1, 0, 1'b1);
    e = $urandom_range(0, 9);
    k = $urandom_range(1, 3);
    run_seq(e, k, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
